branch_target_buffer: RTL and testbench

IF-stage branch predictor. It produces the per-fetch prediction (hit, taken, target) that the IF/ID register carries into Decode. It is the producing end of the btb_hit/btb_predict_taken/btb_target path, and the sink of branch-resolution updates coming back from EX.
- Direct-mapped table; each entry holds valid, tag, target and a 2-bit saturating counter.
- Lookup is combinational, so a prediction is available in the same cycle as fetch.
- Updates and invalidation are synchronous.

---
 rtl/btb_pkg.sv | 24 ++
 rtl/btb_sat_counter.sv | 22 ++
 rtl/branch_target_buffer.sv | 91 +++++++++
 tb/tb_branch_target_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types for the IF-stage branch target buffer.
// Holds the counter encoding, the table entry layout and reset/allocate values.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Tag field is sized for the smallest legal table (ENTRIES=2, 29-bit tag)
    // plus headroom. Larger tables zero-extend their narrower tag into it.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } btb_entry_t;

    localparam ctr_t CTR_ALLOC = WT;
    localparam ctr_t CTR_RESET = WNT;

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state logic for a 2-bit saturating branch direction counter.
// Ports: ctr (current state), taken (resolved outcome), ctr_next (new state).
module btb_sat_counter
    import btb_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (ctr)
            SNT: ctr_next = taken ? WNT : SNT;
            WNT: ctr_next = taken ? WT  : SNT;
            WT:  ctr_next = taken ? ST  : WNT;
            ST:  ctr_next = taken ? ST  : WT;
            default: ctr_next = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup at fetch,
// synchronous training from EX, bulk invalidate, async active-high reset.
// Ports: clk, rst; pcF -> btb_hitF/btb_predict_takenF/btb_targetF;
//        update_en/update_pc/update_taken/update_target; inval_all.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = $clog2(ENTRIES),
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        btb_hitF,
    output logic        btb_predict_takenF,
    output logic [31:0] btb_targetF,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        inval_all
);

    btb_entry_t entries_q [ENTRIES];

    logic [INDEX_BITS-1:0] idx;
    logic [29:0]           tag;
    btb_entry_t            look;

    logic [INDEX_BITS-1:0] uidx;
    logic [29:0]           utag;
    btb_entry_t            cur;
    logic                  uhit;
    ctr_t                  ctr_next;

    // Byte-offset bits of both PCs carry no information for 4-byte fetch.
    logic unused_offset;
    assign unused_offset = ^{pcF[1:0], update_pc[1:0]};

    // Fetch-side lookup, zero latency, reads pre-update contents.
    assign idx  = pcF[INDEX_BITS+1:2];
    assign tag  = 30'(pcF[31:INDEX_BITS+2]);
    assign look = entries_q[idx];

    assign btb_hitF           = look.valid && (look.tag == tag);
    assign btb_predict_takenF = btb_hitF && look.ctr[1];
    assign btb_targetF        = btb_hitF ? look.target : 32'h0;

    // Training side.
    assign uidx = update_pc[INDEX_BITS+1:2];
    assign utag = 30'(update_pc[31:INDEX_BITS+2]);
    assign cur  = entries_q[uidx];
    assign uhit = cur.valid && (cur.tag == utag);

    btb_sat_counter u_ctr (
        .ctr      (cur.ctr),
        .taken    (update_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '{valid:  1'b0,
                                  tag:    30'h0,
                                  target: 32'h0,
                                  ctr:    CTR_RESET};
            end
        end else if (inval_all) begin
            // Bulk flush wins; any coincident training is dropped.
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (update_en) begin
            if (uhit) begin
                entries_q[uidx].ctr <= ctr_next;
                if (update_taken) begin
                    entries_q[uidx].target <= update_target;
                end
            end else if (update_taken) begin
                // Only taken branches earn a slot; aliases are evicted.
                entries_q[uidx] <= '{valid:  1'b1,
                                     tag:    utag,
                                     target: update_target,
                                     ctr:    CTR_ALLOC};
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        btb_hitF;
    logic        btb_predict_takenF;
    logic [31:0] btb_targetF;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        inval_all;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .pcF                (pcF),
        .btb_hitF           (btb_hitF),
        .btb_predict_takenF (btb_predict_takenF),
        .btb_targetF        (btb_targetF),
        .update_en          (update_en),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .inval_all          (inval_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one training update for a single clock edge.
    task automatic do_update(input logic [31:0] pc,
                             input logic        tk,
                             input logic [31:0] tgt);
        update_en     = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
        step();
        update_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pcF = 32'h0000_0040;
        update_en = 1'b0;
        update_pc = 32'h0;
        update_taken = 1'b0;
        update_target = 32'h0;
        inval_all = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;
        step();
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hit got=%b exp=0", btb_hitF);
        end
        n_checks++;
        if (btb_predict_takenF !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_taken got=%b exp=0", btb_predict_takenF);
        end
        n_checks++;
        if (btb_targetF !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_target got=%h exp=0", btb_targetF);
        end
    endtask

    task automatic test_allocate();
        pcF           = 32'h40;
        update_en     = 1'b1;
        update_pc     = 32'h40;
        update_taken  = 1'b1;
        update_target = 32'h100;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_same_cycle_hit got=%b exp=0", btb_hitF);
        end
        step();
        update_en = 1'b0;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b1) begin
            n_fail++;
            $display("FAIL alloc_hit got=%b exp=1", btb_hitF);
        end
        n_checks++;
        if (btb_predict_takenF !== 1'b1) begin
            n_fail++;
            $display("FAIL alloc_taken got=%b exp=1", btb_predict_takenF);
        end
        n_checks++;
        if (btb_targetF !== 32'h100) begin
            n_fail++;
            $display("FAIL alloc_target got=%h exp=100", btb_targetF);
        end
    endtask

    task automatic test_saturation();
        logic exp_nt [3] = '{1'b0, 1'b0, 1'b0};
        logic exp_tk [2] = '{1'b0, 1'b1};
        pcF = 32'h40;
        // WT -> WNT -> SNT -> SNT
        for (int i = 0; i < 3; i++) begin
            do_update(32'h40, 1'b0, 32'hDEAD_0000);
            #1;
            n_checks++;
            if (btb_predict_takenF !== exp_nt[i]) begin
                n_fail++;
                $display("FAIL sat_nt%0d_taken got=%b exp=%b",
                         i, btb_predict_takenF, exp_nt[i]);
            end
        end
        n_checks++;
        if (btb_hitF !== 1'b1 || btb_targetF !== 32'h100) begin
            n_fail++;
            $display("FAIL sat_nt_entry got=%b/%h exp=1/100",
                     btb_hitF, btb_targetF);
        end
        // SNT -> WNT -> WT
        for (int i = 0; i < 2; i++) begin
            do_update(32'h40, 1'b1, 32'h100);
            #1;
            n_checks++;
            if (btb_predict_takenF !== exp_tk[i]) begin
                n_fail++;
                $display("FAIL sat_tk%0d_taken got=%b exp=%b",
                         i, btb_predict_takenF, exp_tk[i]);
            end
        end
        // WT -> ST -> ST, target retrained on taken hit
        do_update(32'h40, 1'b1, 32'h100);
        do_update(32'h40, 1'b1, 32'h180);
        #1;
        n_checks++;
        if (btb_targetF !== 32'h180) begin
            n_fail++;
            $display("FAIL sat_retarget got=%h exp=180", btb_targetF);
        end
        // ST -> WT (still taken) -> WNT
        do_update(32'h40, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (btb_predict_takenF !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_st_dec1 got=%b exp=1", btb_predict_takenF);
        end
        do_update(32'h40, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (btb_predict_takenF !== 1'b0 || btb_targetF !== 32'h180) begin
            n_fail++;
            $display("FAIL sat_st_dec2 got=%b/%h exp=0/180",
                     btb_predict_takenF, btb_targetF);
        end
    endtask

    task automatic test_not_taken_miss();
        do_update(32'h80, 1'b0, 32'h500);
        pcF = 32'h80;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0 || btb_targetF !== 32'h0) begin
            n_fail++;
            $display("FAIL nt_miss got=%b/%h exp=0/0", btb_hitF, btb_targetF);
        end
    endtask

    task automatic test_alias();
        do_update(32'h440, 1'b1, 32'h200);
        pcF = 32'h40;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_old_hit got=%b exp=0", btb_hitF);
        end
        pcF = 32'h440;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b1 || btb_predict_takenF !== 1'b1 ||
            btb_targetF !== 32'h200) begin
            n_fail++;
            $display("FAIL alias_new got=%b/%b/%h exp=1/1/200",
                     btb_hitF, btb_predict_takenF, btb_targetF);
        end
    endtask

    task automatic test_index_boundary();
        // Top index (15); offset bits on both sides must be ignored.
        do_update(32'h0000_003E, 1'b1, 32'h0000_0ABC);
        pcF = 32'h0000_003F;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b1 || btb_targetF !== 32'h0000_0ABC) begin
            n_fail++;
            $display("FAIL idx15_offset got=%b/%h exp=1/abc",
                     btb_hitF, btb_targetF);
        end
        pcF = 32'h8000_003C;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL idx15_tag_msb got=%b exp=0", btb_hitF);
        end
    endtask

    task automatic test_inval();
        inval_all     = 1'b1;
        update_en     = 1'b1;
        update_pc     = 32'h48;
        update_taken  = 1'b1;
        update_target = 32'h600;
        step();
        inval_all = 1'b0;
        update_en = 1'b0;
        pcF = 32'h48;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL inval_upd_48 got=%b exp=0", btb_hitF);
        end
        pcF = 32'h440;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL inval_440 got=%b exp=0", btb_hitF);
        end
        pcF = 32'h3C;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL inval_3c got=%b exp=0", btb_hitF);
        end
    endtask

    task automatic test_async_reset();
        do_update(32'h100, 1'b1, 32'h300);
        pcF = 32'h100;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b1 || btb_targetF !== 32'h300) begin
            n_fail++;
            $display("FAIL arst_pre got=%b/%h exp=1/300",
                     btb_hitF, btb_targetF);
        end
        // Mid-cycle, well before the next rising edge.
        rst = 1'b1;
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0 || btb_targetF !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_mid got=%b/%h exp=0/0",
                     btb_hitF, btb_targetF);
        end
        step();
        rst = 1'b0;
        step();
        #1;
        n_checks++;
        if (btb_hitF !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_post got=%b exp=0", btb_hitF);
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_not_taken_miss();
        test_alias();
        test_index_boundary();
        test_inval();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
